// File: rtl/wallace_multiplier_32x32.sv
// Unsigned 32x32 -> 64-bit Wallace-tree multiplier with one registered output stage.
// AND-array partial products, carry-save row reduction down to two rows, then a ripple adder.
module wallace_multiplier_32x32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] c,
    output logic        out_valid
);

    localparam int unsigned OP_W    = 32;
    localparam int unsigned PROD_W  = 64;
    localparam int unsigned LAYERS  = 8;

    // Rows remaining after l reduction layers: each full group of three becomes two.
    function automatic int unsigned rows_at(input int unsigned l);
        int unsigned n;
        n = OP_W;
        for (int unsigned k = 0; k < l; k++) begin
            n = (n / 3) * 2 + (n % 3);
        end
        return n;
    endfunction

    // Start index of layer l inside the flattened row store.
    function automatic int unsigned row_base(input int unsigned l);
        int unsigned s;
        s = 0;
        for (int unsigned k = 0; k < l; k++) begin
            s = s + rows_at(k);
        end
        return s;
    endfunction

    localparam int unsigned TOTAL_ROWS = row_base(LAYERS + 1);
    localparam int unsigned FINAL_BASE = row_base(LAYERS);

    logic [PROD_W-1:0] rows [TOTAL_ROWS];
    logic [PROD_W-1:0] product;

    // Layer 0: row i holds pp[i][j] = a[j] & b[i], weighted by 2^i.
    for (genvar i = 0; i < OP_W; i++) begin : g_pp
        assign rows[i] = PROD_W'(a & {OP_W{b[i]}}) << i;
    end

    // Each layer feeds rows in threes through a bank of full adders per bit column.
    // Bits carried past 63 are always zero because every partial sum is below 2^64.
    for (genvar l = 0; l < LAYERS; l++) begin : g_layer
        localparam int unsigned N      = rows_at(l);
        localparam int unsigned BASE   = row_base(l);
        localparam int unsigned NBASE  = row_base(l + 1);
        localparam int unsigned GROUPS = N / 3;
        localparam int unsigned LEFT   = N % 3;

        for (genvar g = 0; g < GROUPS; g++) begin : g_fa
            logic [PROD_W-1:0] x, y, z;
            logic [PROD_W-1:0] sum, cry;
            assign x   = rows[BASE + 3*g];
            assign y   = rows[BASE + 3*g + 1];
            assign z   = rows[BASE + 3*g + 2];
            assign sum = x ^ y ^ z;
            assign cry = (x & y) | (x & z) | (y & z);
            assign rows[NBASE + 2*g]     = sum;
            assign rows[NBASE + 2*g + 1] = {cry[PROD_W-2:0], 1'b0};
        end

        for (genvar k = 0; k < LEFT; k++) begin : g_pass
            assign rows[NBASE + 2*GROUPS + k] = rows[BASE + 3*GROUPS + k];
        end
    end

    // Final carry-propagate adder over the two surviving rows.
    logic [PROD_W-1:0] fx, fy;
    logic [PROD_W-1:0] carry;
    assign fx       = rows[FINAL_BASE];
    assign fy       = rows[FINAL_BASE + 1];
    assign carry[0] = 1'b0;

    for (genvar i = 0; i < PROD_W; i++) begin : g_cpa
        assign product[i] = fx[i] ^ fy[i] ^ carry[i];
        if (i < PROD_W - 1) begin : g_cout
            assign carry[i+1] = (fx[i] & fy[i]) | (carry[i] & (fx[i] ^ fy[i]));
        end
    end

    // Output stage: capture on valid, hold product otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c <= product;
            end
        end
    end

endmodule

// File: tb/tb_wallace_multiplier_32x32.sv
// Scoreboard bench for wallace_multiplier_32x32: directed cases, boundaries, random stream with a reset pulse.
module tb_wallace_multiplier_32x32;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] c;
    logic        out_valid;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [63:0] sb [$];
    logic [63:0] last_c;

    wallace_multiplier_32x32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c         (c),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, then compare outputs just after the capturing edge.
    task automatic step(input string tag, input logic v, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] exp;
        @(negedge clk);
        in_valid = v;
        a        = x;
        b        = y;
        if (v) sb.push_back(64'(x) * 64'(y));
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 64'(out_valid), 64'(v));
        if (v) begin
            if (sb.size() == 0) begin
                check({tag, "_sb_empty"}, 64'd1, 64'd0);
            end else begin
                exp    = sb.pop_front();
                last_c = exp;
                check(tag, c, exp);
            end
        end else begin
            check({tag, "_hold"}, c, last_c);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        last_c   = '0;

        // Asynchronous reset with live operands, sampled between clock edges.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 32'd5;
        b        = 32'd7;
        #2;
        check("rst_c", c, 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("rst_c_held", c, 64'd0);
        rst_n = 1'b1;
        sb.push_back(64'd35);
        @(posedge clk);
        #1;
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_c", c, sb.pop_front());
        last_c = 64'd35;

        step("seq0", 1'b1, 32'd3, 32'd4);
        check("seq0_const", c, 64'd12);
        step("seq1", 1'b1, 32'd6, 32'd8);
        check("seq1_const", c, 64'd48);
        step("seq2", 1'b1, 32'd10, 32'd13);
        check("seq2_const", c, 64'd130);

        step("large", 1'b1, 32'd123123123, 32'd121212121);
        check("large_const", c, 64'd14924014882973883);

        step("max", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("max_const", c, 64'hFFFF_FFFE_0000_0001);
        step("msb", 1'b1, 32'h8000_0000, 32'd2);
        check("msb_const", c, 64'h1_0000_0000);
        step("zero", 1'b1, 32'd0, 32'hFFFF_FFFF);
        check("zero_const", c, 64'd0);
        step("ident", 1'b1, 32'd1, 32'hDEAD_BEEF);
        check("ident_const", c, 64'hDEAD_BEEF);

        step("hold_in", 1'b1, 32'd9, 32'd9);
        step("hold", 1'b0, 32'd2, 32'd2);
        check("hold_const", c, 64'd81);
        step("hold2", 1'b0, 32'd3, 32'd3);

        for (int i = 0; i < 10000; i++) begin
            logic        v;
            logic [31:0] x, y;
            if (i == 5000) begin
                // Reset pulse between edges drops any in-flight product.
                @(negedge clk);
                in_valid = 1'b1;
                rst_n    = 1'b0;
                #1;
                check("mid_rst_c", c, 64'd0);
                check("mid_rst_valid", 64'(out_valid), 64'd0);
                sb.delete();
                last_c = '0;
                #1;
                rst_n = 1'b1;
            end
            v = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       x = 32'hFFFF_FFFF;
                1:       x = 32'd0;
                default: x = $urandom;
            endcase
            y = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
            step("rand", v, x, y);
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wallace_multiplier_32x32.md
Name: wallace_multiplier_32x32

Overview:
- Unsigned 32x32 -> 64-bit multiplier built as a Wallace tree.
- Serves as the registered multiply unit for datapath blocks that need a full-width product one clock after operands are presented.
- Arithmetic core is combinational: AND-array partial products, Wallace 3:2/2:2 reduction, final carry-propagate adder.
- A single output register stage is added, with a valid flag.

Parameters:
- None. Widths are fixed: 32-bit operands, 64-bit product.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands on a/b are valid this cycle
- a  input  32  multiplicand, unsigned
- b  input  32  multiplier, unsigned
- c  output  64  registered product a*b, unsigned
- out_valid  output  1  c holds a new product this cycle

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, rst_n.
- Reset: while rst_n=0, c=64'h0 and out_valid=0, immediately and independently of clk.
  - On release, the first capture happens at the next rising clk edge.
  - Reset asserted mid-operation discards any in-flight product. No result for that cycle is produced.
- Arithmetic:
  - c = {32'b0,a} * {32'b0,b}, exact, unsigned.
  - No truncation, no overflow possible. Max 0xFFFFFFFF^2 = 0xFFFFFFFE00000001.
- Latency: 1 cycle.
  - At a rising edge with in_valid=1, c <= a*b and out_valid <= 1.
  - Throughput is one product per cycle; back-to-back valid inputs give back-to-back outputs.
- Idle: at a rising edge with in_valid=0, out_valid <= 0 and c holds its previous value. It is not cleared.
- Partial products: pp[i][j] = a[j] & b[i], i,j = 0..31. Row i is weighted by 2^i (32 rows).
- Reduction:
  - Each layer groups rows in threes through full adders (sum at the same weight, carry at weight+1).
  - Leftover one or two rows pass through unchanged; half adders are allowed where a column has exactly two bits.
  - Repeat until 2 rows remain (8 layers for 32 rows).
- Final adder: 64-bit carry-propagate adder of the two remaining rows. Carry-out beyond bit 63 is provably zero and is discarded.
- Structure: the product must be formed structurally from FA/HA cells and the final adder. A behavioural '*' is not permitted in the synthesizable datapath.
- Zero operand: if a=0 or b=0, then c=0. Identity: if a=1, then c=b.
- Inputs are sampled only at the clock edge. Glitches between edges have no effect.

Test Plan:
- Reset: assert rst_n=0 while clk idles with a=5, b=7, in_valid=1 -> c=0 and out_valid=0 with no clock edge. Release, one edge -> c=35, out_valid=1.
- Small sequence, in_valid=1 each cycle:
  - (3,4) -> 12
  - (6,8) -> 48
  - (10,13) -> 130
  - Each product appears exactly 1 cycle after its operands, back-to-back.
- Large value: a=123123123, b=121212121 -> c=14924014882973883 one cycle later.
- Boundaries:
  - a=b=0xFFFFFFFF -> c=0xFFFFFFFE00000001
  - a=0x80000000, b=2 -> c=0x100000000
  - a=0, b=0xFFFFFFFF -> c=0
  - a=1, b=0xDEADBEEF -> c=0xDEADBEEF
- Hold and valid: apply (9,9) with in_valid=1, then in_valid=0 with a=2, b=2 -> c stays 81, out_valid drops to 0 the following cycle.
- Random: 10,000 random (a,b) pairs with random in_valid gaps -> c matches a 64-bit reference product at 1-cycle latency. out_valid mirrors in_valid delayed by one cycle. Include an rst_n pulse mid-stream and check both outputs clear asynchronously.
